// File: rtl/ysyx_25040109_pkg.sv
// Shared definitions for the load-store unit: FSM state encoding, access size codes
// and the request legality check.
package ysyx_25040109_pkg;

    typedef enum logic [2:0] {
        LSU_IDLE  = 3'd0,
        LSU_RADDR = 3'd1,
        LSU_RDATA = 3'd2,
        LSU_WRITE = 3'd3,
        LSU_RESP  = 3'd4
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // True when the access can never reach the bus: misaligned, or size code 3.
    function automatic logic req_is_bad(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/ysyx_25040109_lsu_align.sv
// Lane logic for the LSU: store byte-enable mask and load extract/sign-extend.
// Purely combinational; the data path is fixed at 32 bits.
module ysyx_25040109_lsu_align
    import ysyx_25040109_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  wmask_o,
    output logic [31:0] ld_data_o
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lane[gi] = rdata_i[gi*8 +: 8];
    end

    assign byte_sel = lane[addr_lo_i];
    // Halves are only ever aligned here, so addr_lo_i[1] alone picks the half.
    assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        wmask_o   = 4'b0000;
        ld_data_o = 32'd0;
        case (size_i)
            SZ_B: begin
                wmask_o   = 4'b0001 << addr_lo_i;
                ld_data_o = {{24{~unsigned_i & byte_sel[7]}}, byte_sel};
            end
            SZ_H: begin
                wmask_o   = 4'b0011 << addr_lo_i;
                ld_data_o = {{16{~unsigned_i & half_sel[15]}}, half_sel};
            end
            SZ_W: begin
                wmask_o   = 4'b1111;
                ld_data_o = rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/ysyx_25040109_lsu.sv
// Load-store unit bus initiator: one outstanding load/store over AR/R and AW/W channels.
// Define YSYX_25040109_LSU_TIMEOUT_EN to add a bus watchdog that ends stalled accesses with an error.
module ysyx_25040109_lsu
    import ysyx_25040109_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] dmem_araddr,
    output logic              dmem_arvalid,
    input  logic              dmem_arready,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_rvalid,
    output logic              dmem_rready,
    output logic [ADDR_W-1:0] dmem_awaddr,
    output logic              dmem_awvalid,
    input  logic              dmem_awready,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic [3:0]        dmem_wmask,
    output logic              dmem_wen,
    output logic              dmem_wvalid,
    input  logic              dmem_wready
);

    if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("ysyx_25040109_lsu: DATA_W must be 32 and TIMEOUT_CYCLES at least 1");
    end

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q, w_done_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       ld_data;

    ysyx_25040109_lsu_align u_align (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .addr_lo_i  (addr_q[1:0]),
        .rdata_i    (dmem_rdata),
        .wmask_o    (dmem_wmask),
        .ld_data_o  (ld_data)
    );

    // Every handshake output decodes from registered state only, so reset clears them at once.
    assign req_ready    = (state_q == LSU_IDLE);
    assign resp_valid   = (state_q == LSU_RESP);
    assign resp_rdata   = rdata_q;
    assign resp_err     = err_q;
    assign dmem_araddr  = addr_q;
    assign dmem_arvalid = (state_q == LSU_RADDR);
    assign dmem_rready  = (state_q == LSU_RDATA);
    assign dmem_awaddr  = addr_q;
    assign dmem_awvalid = (state_q == LSU_WRITE) && !aw_done_q;
    assign dmem_wvalid  = (state_q == LSU_WRITE) && !w_done_q;
    assign dmem_wen     = dmem_wvalid;
    assign dmem_wdata   = wdata_q;

`ifdef YSYX_25040109_LSU_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        tmo_hit;
    logic        bus_wait;

    assign bus_wait = (state_q == LSU_RADDR) || (state_q == LSU_RDATA) || (state_q == LSU_WRITE);
    assign tmo_hit  = bus_wait && (tmo_q == 16'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        size_d    = size_q;
        uns_d     = uns_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        case (state_q)
            LSU_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    size_d    = req_size;
                    uns_d     = req_unsigned;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    rdata_d   = '0;
                    err_d     = 1'b0;
                    if (req_is_bad(req_size, req_addr[1:0])) begin
                        err_d   = 1'b1;
                        state_d = LSU_RESP;
                    end else if (req_wen) begin
                        state_d = LSU_WRITE;
                    end else begin
                        state_d = LSU_RADDR;
                    end
                end
            end
            LSU_RADDR: begin
                if (dmem_arready) state_d = LSU_RDATA;
            end
            LSU_RDATA: begin
                if (dmem_rvalid) begin
                    rdata_d = ld_data;
                    state_d = LSU_RESP;
                end
            end
            LSU_WRITE: begin
                aw_done_d = aw_done_q | dmem_awready;
                w_done_d  = w_done_q | dmem_wready;
                if (aw_done_d && w_done_d) state_d = LSU_RESP;
            end
            LSU_RESP: begin
                if (resp_ready) state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
`ifdef YSYX_25040109_LSU_TIMEOUT_EN
        // A handshake completing on the final cycle still wins over the watchdog.
        if (tmo_hit && (state_d == state_q)) begin
            state_d = LSU_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
        end
        tmo_d = (bus_wait && (state_d == state_q)) ? tmo_q + 16'd1 : 16'd0;
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= LSU_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            size_q    <= size_d;
            uns_q     <= uns_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
        end
    end

`ifdef YSYX_25040109_LSU_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmo_q <= 16'd0;
        else      tmo_q <= tmo_d;
    end
`endif

endmodule

// File: tb/tb_ysyx_25040109_lsu.sv
// Directed bench for the LSU: table of load/store vectors against a small responder model,
// plus hand sequences for response backpressure, reset mid-load and a stalled AR channel.
module tb_ysyx_25040109_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_wen = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] dmem_araddr;
    logic        dmem_arvalid;
    logic        dmem_arready = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_rvalid = 1'b0;
    logic        dmem_rready;
    logic [31:0] dmem_awaddr;
    logic        dmem_awvalid;
    logic        dmem_awready = 1'b0;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wmask;
    logic        dmem_wen;
    logic        dmem_wvalid;
    logic        dmem_wready = 1'b0;

    always #5 clk = ~clk;

    ysyx_25040109_lsu dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .dmem_araddr  (dmem_araddr),
        .dmem_arvalid (dmem_arvalid),
        .dmem_arready (dmem_arready),
        .dmem_rdata   (dmem_rdata),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rready  (dmem_rready),
        .dmem_awaddr  (dmem_awaddr),
        .dmem_awvalid (dmem_awvalid),
        .dmem_awready (dmem_awready),
        .dmem_wdata   (dmem_wdata),
        .dmem_wmask   (dmem_wmask),
        .dmem_wen     (dmem_wen),
        .dmem_wvalid  (dmem_wvalid),
        .dmem_wready  (dmem_wready)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] mem_rdata;
        int          ar_lat;     // cycles arvalid is left waiting before arready
        int          wmode;      // 0: AW and W together, 1: AW first, W one cycle later
        int          resp_hold;  // cycles resp_ready is withheld
        logic        exp_err;
        logic [31:0] exp_rdata;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_word;   // responder word after the store, starting from zero
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    task automatic run_txn(input int id, input vec_t v);
        logic        saw_ar = 1'b0, saw_aw = 1'b0, ar_bad = 1'b0, split_seen = 1'b0;
        logic        got_resp = 1'b0, w_fired = 1'b0, wen_bad = 1'b0;
        logic [3:0]  cap_mask = '0;
        logic [31:0] cap_wdata = '0, word = '0, bm, held;
        int          ar_cnt = 0, cyc = 0, resp_cyc = -1;

        @(negedge clk);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_wen = v.wen; req_addr = v.addr; req_wdata = v.wdata;
        req_size = v.size; req_unsigned = v.uns;
        @(negedge clk);
        req_valid = 1'b0;
        while (!got_resp && cyc < 40) begin
            dmem_arready = 1'b0; dmem_rvalid = 1'b0; dmem_awready = 1'b0; dmem_wready = 1'b0;
            if (dmem_arvalid) begin
                saw_ar = 1'b1;
                if (dmem_araddr !== v.addr) ar_bad = 1'b1;
                dmem_arready = (ar_cnt >= v.ar_lat);
                ar_cnt++;
            end
            if (dmem_rready) begin
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.mem_rdata;
            end
            if (dmem_awvalid) saw_aw = 1'b1;
            if (dmem_wvalid !== dmem_wen) wen_bad = 1'b1;
            if (!dmem_awvalid && dmem_wvalid) split_seen = 1'b1;
            dmem_awready = dmem_awvalid;
            dmem_wready  = (v.wmode == 0) ? dmem_wvalid : (dmem_wvalid && !dmem_awvalid);
            if (dmem_wvalid && dmem_wready) begin
                w_fired = 1'b1; cap_mask = dmem_wmask; cap_wdata = dmem_wdata;
            end
            if (resp_valid) begin
                got_resp = 1'b1;
                resp_cyc = cyc;
                dmem_arready = 1'b0; dmem_rvalid = 1'b0; dmem_awready = 1'b0; dmem_wready = 1'b0;
                check("resp_err", 32'(resp_err), 32'(v.exp_err));
                check("resp_rdata", resp_rdata, v.exp_rdata);
                held = resp_rdata;
                for (int k = 0; k < v.resp_hold; k++) begin
                    @(negedge clk);
                    check("hold_resp_valid", 32'(resp_valid), 32'd1);
                    check("hold_resp_rdata", resp_rdata, held);
                    check("hold_req_ready", 32'(req_ready), 32'd0);
                end
                resp_ready = 1'b1;
                @(negedge clk);
                resp_ready = 1'b0;
                check("after_resp_idle", 32'({resp_valid, req_ready}), 32'b01);
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        if (!got_resp) check("resp_timeout", 32'd0, 32'd1);

        check("bus_ar_activity", 32'(saw_ar), 32'(!v.exp_err && !v.wen));
        check("bus_aw_activity", 32'(saw_aw), 32'(!v.exp_err && v.wen));
        check("araddr_stable", 32'(ar_bad), 32'd0);
        if (v.exp_err) check("err_latency", 32'(resp_cyc <= 1), 32'd1);
        if (!v.exp_err && !v.wen) check("ar_wait_cycles", 32'(ar_cnt), 32'(v.ar_lat + 1));
        if (!v.exp_err && v.wen) begin
            for (int k = 0; k < 4; k++) bm[k*8 +: 8] = {8{cap_mask[k]}};
            if (w_fired) word = (cap_wdata << (8 * v.addr[1:0])) & bm;
            check("wmask", 32'(cap_mask), 32'(v.exp_wmask));
            check("wdata_unshifted", cap_wdata, v.wdata);
            check("mem_word", word, v.exp_word);
            check("w_after_aw_split", 32'(split_seen), 32'(v.wmode == 1));
            check("wen_eq_wvalid", 32'(wen_bad), 32'd0);
        end
        $display("[TB] txn %0d wen=%0b addr=%08h size=%0d -> err=%0b rdata=%08h mask=%b", id, v.wen,
                 v.addr, v.size, resp_err, resp_rdata, cap_mask);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;
        int   ar_hi;
        logic any_resp;

        vecs[0]  = '{1'b0, 32'h8000_0003, 32'h0,         2'd0, 1'b0, 32'h80FF_1234, 2, 0, 0, 1'b0, 32'hFFFF_FF80, 4'h0,    32'h0};
        vecs[1]  = '{1'b0, 32'h8000_0002, 32'h0,         2'd1, 1'b1, 32'hBEEF_0000, 0, 0, 0, 1'b0, 32'h0000_BEEF, 4'h0,    32'h0};
        vecs[2]  = '{1'b0, 32'h8000_0002, 32'h0,         2'd1, 1'b0, 32'hBEEF_0000, 1, 0, 0, 1'b0, 32'hFFFF_BEEF, 4'h0,    32'h0};
        vecs[3]  = '{1'b1, 32'h8000_0001, 32'h0000_00AB, 2'd0, 1'b0, 32'h0,         0, 0, 0, 1'b0, 32'h0,         4'b0010, 32'h0000_AB00};
        vecs[4]  = '{1'b1, 32'h8000_0001, 32'h0000_00AB, 2'd0, 1'b0, 32'h0,         0, 1, 0, 1'b0, 32'h0,         4'b0010, 32'h0000_AB00};
        vecs[5]  = '{1'b1, 32'h8000_0006, 32'h1234_5678, 2'd2, 1'b0, 32'h0,         0, 0, 0, 1'b1, 32'h0,         4'h0,    32'h0};
        vecs[6]  = '{1'b0, 32'h8000_0000, 32'h0,         2'd3, 1'b0, 32'h0,         0, 0, 0, 1'b1, 32'h0,         4'h0,    32'h0};
        vecs[7]  = '{1'b0, 32'h8000_0004, 32'h0,         2'd2, 1'b0, 32'h1234_5678, 0, 0, 5, 1'b0, 32'h1234_5678, 4'h0,    32'h0};
        vecs[8]  = '{1'b0, 32'h8000_0002, 32'h0,         2'd0, 1'b0, 32'h80FF_1234, 0, 0, 0, 1'b0, 32'hFFFF_FFFF, 4'h0,    32'h0};
        vecs[9]  = '{1'b0, 32'h8000_0002, 32'h0,         2'd0, 1'b1, 32'h80FF_1234, 0, 0, 0, 1'b0, 32'h0000_00FF, 4'h0,    32'h0};
        vecs[10] = '{1'b1, 32'h8000_0002, 32'h0000_CAFE, 2'd1, 1'b0, 32'h0,         0, 1, 0, 1'b0, 32'h0,         4'b1100, 32'hCAFE_0000};
        vecs[11] = '{1'b1, 32'h8000_0000, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0,         0, 0, 0, 1'b0, 32'h0,         4'b1111, 32'hDEAD_BEEF};
        vecs[12] = '{1'b0, 32'h8000_0001, 32'h0,         2'd1, 1'b0, 32'h0,         0, 0, 0, 1'b1, 32'h0,         4'h0,    32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_valids", 32'({resp_valid, dmem_arvalid, dmem_rready, dmem_awvalid, dmem_wvalid, dmem_wen}), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_araddr", dmem_araddr, 32'd0);
        rst = 1'b1;

        for (int i = 0; i < NVEC; i++) run_txn(i, vecs[i]);

        // Reset asserted while waiting in RDATA
        @(negedge clk);
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0008; req_size = 2'd2; req_unsigned = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            dmem_arready = dmem_arvalid;
            dmem_rvalid  = 1'b0;
            if (dmem_rready) seen = 1'b1;
            else @(negedge clk);
        end
        dmem_arready = 1'b0;
        check("reach_rdata", 32'(seen), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("async_rst_valids", 32'({resp_valid, dmem_arvalid, dmem_rready, dmem_awvalid, dmem_wvalid}), 32'd0);
        check("async_rst_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 32'({req_ready, resp_valid, dmem_arvalid, dmem_rready}), 32'b1000);
        $display("[TB] txn reset-in-RDATA -> req_ready=%0b resp_valid=%0b", req_ready, resp_valid);

        // AR never accepted: the default build waits indefinitely
        req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h8000_0010; req_size = 2'd2;
        @(negedge clk);
        req_valid = 1'b0;
        ar_hi = 0;
        any_resp = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (dmem_arvalid) ar_hi++;
            if (resp_valid) any_resp = 1'b1;
            @(negedge clk);
        end
        check("stall_ar_held", 32'(ar_hi), 32'd20);
        check("stall_no_resp", 32'(any_resp), 32'd0);
        $display("[TB] txn stalled-AR -> arvalid cycles=%0d resp_seen=%0b", ar_hi, any_resp);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // A normal access still works after the abandoned ones
        run_txn(NVEC, vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
